// File: rtl/simd_issue_stage.sv
// Operand-fetch, issue and writeback stage wrapped around a combinational simd_alu.
// Define SIMD_BYPASS_EN to forward the writeback value to a dependent read instead of stalling.
module simd_issue_stage #(
    parameter int  NUM_REGS = 8,
    parameter int  LANES    = 4,
    parameter int  LANE_W   = 8,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int DW       = LANES * LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic [LANES-1:0] in_mask,
    input  logic             ld_en,
    input  logic [RW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_data,
    output logic [DW-1:0]    alu_vec_a,
    output logic [DW-1:0]    alu_vec_b,
    output logic [1:0]       alu_op,
    output logic [LANES-1:0] alu_mask,
    input  logic [DW-1:0]    alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [RW-1:0]    res_rd
);

    logic [DW-1:0]    rf_q [NUM_REGS];

    logic             x_valid_q, x_valid_d;
    logic [DW-1:0]    x_a_q, x_a_d;
    logic [DW-1:0]    x_b_q, x_b_d;
    logic [DW-1:0]    x_old_q, x_old_d;
    logic [1:0]       x_op_q, x_op_d;
    logic [LANES-1:0] x_mask_q, x_mask_d;
    logic [RW-1:0]    x_rd_q, x_rd_d;

    logic             wb_fire;
    logic             in_fire;
    logic             hazard;
    logic [DW-1:0]    rs1_val, rs2_val, rd_val;

    // Disabled lanes keep the destination's previous contents.
    always_comb begin
        res_data = x_old_q;
        for (int i = 0; i < LANES; i++) begin
            if (x_mask_q[i]) res_data[i*LANE_W +: LANE_W] = alu_result[i*LANE_W +: LANE_W];
        end
    end

    assign wb_fire = x_valid_q && res_ready;

`ifdef SIMD_BYPASS_EN
    assign hazard  = 1'b0;
    assign rs1_val = (wb_fire && (x_rd_q == in_rs1)) ? res_data : rf_q[in_rs1];
    assign rs2_val = (wb_fire && (x_rd_q == in_rs2)) ? res_data : rf_q[in_rs2];
    assign rd_val  = (wb_fire && (x_rd_q == in_rd))  ? res_data : rf_q[in_rd];
`else
    // Without forwarding a dependent instruction waits until its producer has left X.
    assign hazard  = x_valid_q && ((x_rd_q == in_rs1) || (x_rd_q == in_rs2) || (x_rd_q == in_rd));
    assign rs1_val = rf_q[in_rs1];
    assign rs2_val = rf_q[in_rs2];
    assign rd_val  = rf_q[in_rd];
`endif

    assign in_ready = (!x_valid_q || wb_fire) && !hazard;
    assign in_fire  = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        x_valid_d = x_valid_q;
        x_a_d     = x_a_q;
        x_b_d     = x_b_q;
        x_old_d   = x_old_q;
        x_op_d    = x_op_q;
        x_mask_d  = x_mask_q;
        x_rd_d    = x_rd_q;
        if (in_fire) begin
            x_valid_d = 1'b1;
            x_a_d     = rs1_val;
            x_b_d     = rs2_val;
            x_old_d   = rd_val;
            x_op_d    = in_op;
            x_mask_d  = in_mask;
            x_rd_d    = in_rd;
        end else if (wb_fire) begin
            x_valid_d = 1'b0;
        end
    end

    // NOTE: the register file is reset because software expects every register to read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid_q <= 1'b0;
            x_a_q     <= '0;
            x_b_q     <= '0;
            x_old_q   <= '0;
            x_op_q    <= '0;
            x_mask_q  <= '0;
            x_rd_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            x_valid_q <= x_valid_d;
            x_a_q     <= x_a_d;
            x_b_q     <= x_b_d;
            x_old_q   <= x_old_d;
            x_op_q    <= x_op_d;
            x_mask_q  <= x_mask_d;
            x_rd_q    <= x_rd_d;
            // NOTE: the later non-blocking write wins, so writeback overrides a host load to the same register.
            if (ld_en)   rf_q[ld_addr] <= ld_data;
            if (wb_fire) rf_q[x_rd_q]  <= res_data;
        end
    end

    assign alu_vec_a = x_a_q;
    assign alu_vec_b = x_b_q;
    assign alu_op    = x_op_q;
    assign alu_mask  = x_mask_q;
    assign res_valid = x_valid_q;
    assign res_rd    = x_rd_q;

endmodule

// File: tb/tb_simd_issue_stage.sv
// Directed self-checking bench for simd_issue_stage; a lane-wise ALU model closes the loop.
module tb_simd_issue_stage;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic [3:0]  in_mask;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_vec_a, alu_vec_b;
    logic [1:0]  alu_op;
    logic [3:0]  alu_mask;
    logic [31:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    simd_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_mask    (in_mask),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_vec_a  (alu_vec_a),
        .alu_vec_b  (alu_vec_b),
        .alu_op     (alu_op),
        .alu_mask   (alu_mask),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [31:0] r;
        logic [15:0] p;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (op)
                OP_ADD:  r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
                OP_MUL:  begin p = a[i*8 +: 8] * b[i*8 +: 8]; r[i*8 +: 8] = p[7:0]; end
                OP_AND:  r[i*8 +: 8] = a[i*8 +: 8] & b[i*8 +: 8];
                default: r[i*8 +: 8] = a[i*8 +: 8] | b[i*8 +: 8];
            endcase
        end
        return r;
    endfunction

    assign alu_result = alu_model(alu_vec_a, alu_vec_b, alu_op);

    // Called at a falling edge; returns at the falling edge after acceptance with in_valid low.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [3:0] mask, output int stalls);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_mask  = mask;
        stalls   = 0;
        #1;
        while (!in_ready && stalls < 20) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        tests++;
        if (!in_ready) begin
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, stalls);
            fails++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [31:0] v);
        int st;
        issue(OP_OR, r, r, r, 4'hF, st);
        v = res_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_mask = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_handshake: res_valid=%b in_ready=%b, required 0/1", res_valid, in_ready);
            fails++;
        end
        tests++;
        if (alu_vec_a !== 32'h0 || alu_vec_b !== 32'h0 || res_data !== 32'h0 ||
            alu_op !== 2'b0 || alu_mask !== 4'h0 || res_rd !== 3'd0) begin
            $display("FAIL reset_outputs: a=%h b=%h res=%h op=%h mask=%h rd=%0d, required all 0",
                     alu_vec_a, alu_vec_b, res_data, alu_op, alu_mask, res_rd);
            fails++;
        end
    endtask

    task automatic test_add;
        int st;
        load(3'd1, 32'h01020304);
        load(3'd2, 32'h05060708);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 4'b1111, st);
        tests++;
        if (alu_vec_a !== 32'h01020304 || alu_vec_b !== 32'h05060708) begin
            $display("FAIL add_operands: a=%h b=%h, required 01020304/05060708", alu_vec_a, alu_vec_b);
            fails++;
        end
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'h06080A0C || res_rd !== 3'd3) begin
            $display("FAIL add_result: valid=%b data=%h rd=%0d, required 1/06080a0c/3",
                     res_valid, res_data, res_rd);
            fails++;
        end
    endtask

    task automatic test_back_to_back;
        int st;
        int exp_stalls;
        logic [31:0] v;
`ifdef SIMD_BYPASS_EN
        exp_stalls = 0;
`else
        exp_stalls = 1;
`endif
        issue(OP_MUL, 3'd4, 3'd3, 3'd1, 4'b0101, st);
        tests++;
        if (st != exp_stalls) begin
            $display("FAIL dep_stalls: %0d stall cycles, required %0d", st, exp_stalls);
            fails++;
        end
        tests++;
        if (alu_vec_a !== 32'h06080A0C || alu_vec_b !== 32'h01020304) begin
            $display("FAIL dep_operands: a=%h b=%h, required 06080a0c/01020304", alu_vec_a, alu_vec_b);
            fails++;
        end
        tests++;
        if (res_data !== 32'h00100030 || res_rd !== 3'd4) begin
            $display("FAIL dep_result: data=%h rd=%0d, required 00100030/4", res_data, res_rd);
            fails++;
        end
        read_reg(3'd3, v);
        tests++;
        if (v !== 32'h06080A0C) begin
            $display("FAIL rf_r3: got %h, required 06080a0c", v);
            fails++;
        end
        read_reg(3'd4, v);
        tests++;
        if (v !== 32'h00100030) begin
            $display("FAIL rf_r4: got %h, required 00100030", v);
            fails++;
        end
    endtask

    task automatic test_mask_merge;
        int st;
        logic [31:0] v;
        load(3'd5, 32'h0C0B0A09);
        load(3'd6, 32'h00010002);
        load(3'd7, 32'hFFFFFFFF);
        issue(OP_AND, 3'd7, 3'd5, 3'd6, 4'b1010, st);
        tests++;
        if (res_data !== 32'h00FF00FF || alu_mask !== 4'b1010) begin
            $display("FAIL and_merge: data=%h mask=%b, required 00ff00ff/1010", res_data, alu_mask);
            fails++;
        end
        read_reg(3'd7, v);
        tests++;
        if (v !== 32'h00FF00FF) begin
            $display("FAIL rf_r7: got %h, required 00ff00ff", v);
            fails++;
        end
    endtask

    task automatic test_backpressure;
        int st;
        logic [31:0] v;
        issue(OP_ADD, 3'd6, 3'd6, 3'd6, 4'hF, st);
        res_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_OR; in_rd = 3'd0; in_rs1 = 3'd1; in_rs2 = 3'd1; in_mask = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'h00020004 ||
                alu_vec_a !== 32'h00010002 || res_rd !== 3'd6) begin
                $display("FAIL stall_hold[%0d]: ready=%b valid=%b data=%h a=%h rd=%0d, required 0/1/00020004/00010002/6",
                         k, in_ready, res_valid, res_data, alu_vec_a, res_rd);
                fails++;
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            $display("FAIL stall_release: in_ready=%b, required 1", in_ready);
            fails++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (res_rd !== 3'd0 || res_data !== 32'h01020304) begin
            $display("FAIL stall_next: rd=%0d data=%h, required 0/01020304", res_rd, res_data);
            fails++;
        end
        read_reg(3'd6, v);
        tests++;
        if (v !== 32'h00020004) begin
            $display("FAIL rf_r6: got %h, required 00020004", v);
            fails++;
        end
    endtask

    task automatic test_load_collision;
        int st;
        logic [31:0] v;
        issue(OP_OR, 3'd3, 3'd1, 3'd2, 4'hF, st);
        tests++;
        if (res_data !== 32'h0506070C) begin
            $display("FAIL or_result: got %h, required 0506070c", res_data);
            fails++;
        end
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 32'hDEADBEEF;
        @(negedge clk);
        ld_en = 1'b0;
        read_reg(3'd3, v);
        tests++;
        if (v !== 32'h0506070C) begin
            $display("FAIL wb_beats_ld: r3=%h, required 0506070c", v);
            fails++;
        end
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_OR; in_rd = 3'd0; in_rs1 = 3'd2; in_rs2 = 3'd2; in_mask = 4'hF;
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'hAABBCCDD;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ld_en = 1'b0;
        tests++;
        if (res_data !== 32'h05060708) begin
            $display("FAIL ld_no_forward: got %h, required 05060708", res_data);
            fails++;
        end
        read_reg(3'd2, v);
        tests++;
        if (v !== 32'hAABBCCDD) begin
            $display("FAIL rf_r2_loaded: got %h, required aabbccdd", v);
            fails++;
        end
    endtask

    task automatic test_reset_midop;
        int st;
        logic [31:0] v;
        issue(OP_ADD, 3'd5, 3'd1, 3'd2, 4'hF, st);
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'hABBDCFE1) begin
            $display("FAIL pre_reset: valid=%b data=%h, required 1/abbdcfe1", res_valid, res_data);
            fails++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (res_valid !== 1'b0 || res_data !== 32'h0 || alu_vec_a !== 32'h0 || alu_vec_b !== 32'h0 ||
            alu_op !== 2'b0 || alu_mask !== 4'h0 || res_rd !== 3'd0) begin
            $display("FAIL async_reset: valid=%b data=%h a=%h b=%h op=%h mask=%h rd=%0d, required all 0",
                     res_valid, res_data, alu_vec_a, alu_vec_b, alu_op, alu_mask, res_rd);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        read_reg(3'd5, v);
        tests++;
        if (v !== 32'h0) begin
            $display("FAIL dropped_wb_r5: got %h, required 0", v);
            fails++;
        end
        read_reg(3'd1, v);
        tests++;
        if (v !== 32'h0) begin
            $display("FAIL rf_cleared_r1: got %h, required 0", v);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mask_merge();
        test_backpressure();
        test_load_collision();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/simd_issue_stage.md
Name: simd_issue_stage

Overview:
- Operand-fetch, issue and writeback stage wrapped around the combinational simd_alu.
- Holds the vector register file and accepts instructions on a valid/ready stream.
- Drives registered vec_a, vec_b, op and mask to the ALU.
- Takes the ALU result, writes enabled lanes back to rd, and emits the merged result on an output stream.

Parameters:
- NUM_REGS, 8: number of vector registers; index width RW = $clog2(NUM_REGS).
- LANES, 4: lanes per vector; mask width.
- LANE_W, 8: bits per lane; vector width DW = LANES*LANE_W = 32.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_op  in  2  00 ADD, 01 MUL, 10 AND, 11 OR (passed to ALU).
- in_rd, in_rs1, in_rs2  in  RW each  destination and sources.
- in_mask  in  LANES  lane enables; bit i = lane i = bits [i*LANE_W +: LANE_W].
- ld_en  in  1  host full-register load.
- ld_addr  in  RW  host load address.
- ld_data  in  DW  host load data.
- alu_vec_a, alu_vec_b  out  DW  registered operands to simd_alu.
- alu_op  out  2  registered op.
- alu_mask  out  LANES  registered mask.
- alu_result  in  DW  combinational result from simd_alu.
- res_valid  out  1  merged result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DW  merged value written to rd.
- res_rd  out  RW  destination of res_data.

Behaviour:
- Reset: all registers 0; alu_vec_a/alu_vec_b/res_data 0; alu_op, alu_mask, res_rd 0; res_valid 0. Reset mid-operation drops the in-flight instruction and performs no writeback.
- Pipeline register X:
  - Holds valid, vec_a, vec_b, op, mask, rd, old_rd.
  - res_valid = X.valid.
  - res_data is combinational: lane i = alu_result lane i if mask[i], else old_rd lane i.
- wb_fire = X.valid && res_ready.
  - On wb_fire edge: RF[rd] <= res_data.
- in_ready = !X.valid || wb_fire.
  - in_fire = in_valid && in_ready.
  - On in_fire: X loads rs1/rs2/rd reads, in_op, in_mask; X.valid=1.
  - Else if wb_fire: X.valid=0.
  - Else X holds unchanged; outputs are stable while res_valid && !res_ready.
- Latency: instruction accepted at edge N; result on res_* during cycle N+1; RF updated at the first edge with res_ready=1. Throughput is 1 instr/cycle when res_ready=1.
- Reads are RF reads with the forwarding rule (see Optional Feature).
- Host load:
  - ld_en writes ld_data to RF[ld_addr] at the edge.
  - Same edge and same address as wb_fire: writeback wins.
  - ld is not forwarded to a same-cycle read; the read returns the pre-edge value.
- All arithmetic lives in the ALU; this block does no lane arithmetic and never carries across lanes.

Optional Feature:
- Macro SIMD_BYPASS_EN.
- Defined:
  - If wb_fire and in_fire coincide and rs1/rs2/rd equals X.rd, the read returns res_data (merged) instead of the stale RF value.
  - Back-to-back dependent instructions therefore issue without stall.
- Undefined:
  - No forwarding.
  - in_ready is additionally forced 0 while X.valid and X.rd matches in_rs1, in_rs2 or in_rd.
  - The instruction issues the cycle after writeback completes, adding 1 bubble per dependency.

Test Plan:
- Load r1=32'h01020304, r2=32'h05060708. Issue ADD r3,r1,r2, mask 1111 -> next cycle alu_vec_a=01020304, alu_vec_b=05060708, res_data=06080A0C, res_rd=3; r3=06080A0C after the edge.
- Immediately after, issue MUL r4,r3,r1, mask 0101 (r4=0):
  - With bypass: issues with no stall, alu_vec_a=06080A0C, res_data=00100030.
  - Without bypass: in_ready low for 1 cycle, same result.
- Load r5=0C0B0A09, r6=00010002, r7=FFFFFFFF. Issue AND r7,r5,r6, mask 1010 -> res_data=00FF00FF (lanes 0 and 2 keep FF).
- Hold res_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, res_* and alu_* stable, no RF change. The 4th cycle with res_ready=1 writes back and accepts the next instruction.
- ld_en to r3 on the same edge as wb_fire to r3 -> r3 holds the writeback value.
- Assert rst_n=0 while res_valid=1 -> res_valid=0 and all outputs 0 immediately (async). The RF reads back 0 and the dropped instruction does not write.
